// File: rtl/cam_csr_pkg.sv
// cam_csr_pkg: shared state type, register map and bit indices for cam_capture_csr
package cam_csr_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
  localparam int ADDR_ID         = 0;
  localparam int ADDR_CTRL       = 1;
  localparam int ADDR_STATUS     = 2;
  localparam int ADDR_FRAME_CNT  = 3;
  localparam int ADDR_LAST_LINES = 4;
  localparam int ADDR_EXP_LINES  = 5;
  localparam int CTRL_EN         = 0;
  localparam int CTRL_SINGLE     = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_PAT        = 3;
  localparam int ST_BUSY         = 0;
  localparam int ST_DONE         = 1;
  localparam int ST_LERR         = 2;
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: multi-flop synchroniser for an async camera line with rise/fall pulses
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      prev <= sync[STAGES-1];
    end
  assign rise = sync[STAGES-1] & ~prev;
  assign fall = ~sync[STAGES-1] & prev;
endmodule

// File: rtl/cam_capture_csr.sv
// cam_capture_csr: Avalon-MM CSR block and frame-capture gating for the OV7670 path
module cam_capture_csr
  import cam_csr_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 3,
  parameter logic [DATA_W-1:0] ID_VALUE      = 'h2,
  parameter int                LINE_W        = 10,
  parameter int                CNT_W         = 16,
  parameter int                EXP_LINES_RST = 480,
  parameter int                HB_BITS       = 28,
  parameter int                SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              cam_vsync,
  input  logic              cam_href,
  output logic              capture_en,
  output logic              frame_start,
  output logic [1:0]        pattern_sel,
  output logic              irq,
  output logic              led_heartbeat,
  output logic              led_busy
);
  state_t state;
  logic [4:0] ctrl;
  logic done, line_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [LINE_W-1:0] last_lines, exp_lines, line_cnt, line_nxt;
  logic [HB_BITS-1:0] hb;
  logic vs_rise, vs_fall, hr_rise, hr_fall_unused;
  logic wr, rd, en, frame_end, set_err, clr_done, clr_err, clr_cnt, wdata_unused;
  logic [DATA_W-1:0] rmux;
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_vs (
    .clk(clk), .reset(reset), .async_in(cam_vsync), .rise(vs_rise), .fall(vs_fall)
  );
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_hr (
    .clk(clk), .reset(reset), .async_in(cam_href), .rise(hr_rise), .fall(hr_fall_unused)
  );
  assign wr            = chipselect & write;
  assign rd            = chipselect & read;
  assign en            = ctrl[CTRL_EN];
  assign line_nxt      = (hr_rise && !(&line_cnt)) ? line_cnt + 1'b1 : line_cnt;
  // an HREF edge landing on the VSYNC-rise cycle still belongs to this frame
  assign frame_end     = state == CAPTURE && en && vs_rise;
  assign set_err       = frame_end && line_nxt != exp_lines;
  assign clr_done      = wr && address == ADDR_W'(ADDR_STATUS) && writedata[ST_DONE];
  assign clr_err       = wr && address == ADDR_W'(ADDR_STATUS) && writedata[ST_LERR];
  assign clr_cnt       = wr && address == ADDR_W'(ADDR_FRAME_CNT);
  assign wdata_unused  = ^writedata;
  assign pattern_sel   = ctrl[CTRL_PAT+1:CTRL_PAT];
  assign led_busy      = state != IDLE;
  assign led_heartbeat = hb[HB_BITS-1];
  always_comb
    rmux = address == ADDR_W'(ADDR_ID)         ? ID_VALUE
         : address == ADDR_W'(ADDR_CTRL)       ? DATA_W'(ctrl)
         : address == ADDR_W'(ADDR_STATUS)     ? DATA_W'({line_err, done, led_busy})
         : address == ADDR_W'(ADDR_FRAME_CNT)  ? DATA_W'(frame_cnt)
         : address == ADDR_W'(ADDR_LAST_LINES) ? DATA_W'(last_lines)
         : address == ADDR_W'(ADDR_EXP_LINES)  ? DATA_W'(exp_lines)
         : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      ctrl        <= '0;
      done        <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= '0;
      last_lines  <= '0;
      exp_lines   <= LINE_W'(EXP_LINES_RST);
      line_cnt    <= '0;
      capture_en  <= 1'b0;
      frame_start <= 1'b0;
      irq         <= 1'b0;
      hb          <= '0;
      readdata    <= '0;
    end else begin
      hb          <= hb + 1'b1;
      frame_start <= 1'b0;
      irq         <= ctrl[CTRL_IRQ_EN] & (done | line_err);
      if (rd) readdata <= rmux;
      // a CPU write to CTRL overrides the auto-clear of enable on completion
      if (wr && address == ADDR_W'(ADDR_CTRL)) ctrl <= writedata[4:0];
      else if (state == DONE) ctrl[CTRL_EN] <= 1'b0;
      if (wr && address == ADDR_W'(ADDR_EXP_LINES)) exp_lines <= writedata[LINE_W-1:0];
      done      <= (state == DONE) | (done & ~clr_done);
      line_err  <= set_err | (line_err & ~clr_err);
      frame_cnt <= (clr_cnt ? '0 : frame_cnt) + CNT_W'(frame_end);
      if (frame_end) last_lines <= line_nxt;
      case (state)
        IDLE: if (en) state <= ARM;
        ARM:
          if (!en) state <= IDLE;
          else if (vs_fall) begin
            state       <= CAPTURE;
            frame_start <= 1'b1;
            capture_en  <= 1'b1;
            line_cnt    <= '0;
          end
        CAPTURE:
          if (!en) begin
            state      <= IDLE;
            capture_en <= 1'b0;
          end else begin
            line_cnt <= line_nxt;
            if (vs_rise) begin
              capture_en <= 1'b0;
              state      <= ctrl[CTRL_SINGLE] ? DONE : ARM;
            end
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cam_capture_csr.sv
// tb_cam_capture_csr: directed register-table and capture-sequence checks for cam_capture_csr
module tb_cam_capture_csr;
  logic clk = 0, reset = 1, chipselect = 0, read = 0, write = 0, cam_vsync = 1, cam_href = 0;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata, readdata2, rdata, rdata2;
  logic capture_en, frame_start, irq, led_heartbeat, led_busy;
  logic capture_en2, frame_start2, irq2, led_heartbeat2, led_busy2;
  logic [1:0] pattern_sel, pattern_sel2;
  int checks = 0, errors = 0, fs_cnt = 0, fs0 = 0;
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[19];

  cam_capture_csr dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .capture_en(capture_en),
    .frame_start(frame_start), .pattern_sel(pattern_sel), .irq(irq),
    .led_heartbeat(led_heartbeat), .led_busy(led_busy)
  );
  // narrow counters so wrap and heartbeat toggling are reachable in a short run
  cam_capture_csr #(.CNT_W(2), .HB_BITS(4)) dut2 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata2),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .capture_en(capture_en2),
    .frame_start(frame_start2), .pattern_sel(pattern_sel2), .irq(irq2),
    .led_heartbeat(led_heartbeat2), .led_busy(led_busy2)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_start) fs_cnt++;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    tick;
    chipselect = 0; write = 0;
  endtask
  task automatic bus_rd(input logic [2:0] a);
    chipselect = 1; read = 1; address = a;
    tick;
    chipselect = 0; read = 0;
    rdata = readdata; rdata2 = readdata2;
  endtask
  task automatic line_pulses(input int n);
    repeat (n) begin
      cam_href = 1; tick; tick;
      cam_href = 0; tick; tick;
    end
  endtask
  task automatic frame_body(input int n);
    cam_vsync = 0;
    repeat (4) tick;
    line_pulses(n);
    tick; tick;
    cam_vsync = 1;
  endtask
  task automatic frame(input int n);
    frame_body(n);
    repeat (8) tick;
  endtask
  task automatic wait_drop(input string name);
    for (int k = 0; k < 20 && capture_en; k++) tick;
    chk(name, capture_en, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h2,   "id"};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h0,   "ctrl_rst"};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h0,   "status_rst"};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h0,   "fcnt_rst"};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,        32'h0,   "last_rst"};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,        32'd480, "exp_rst"};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,        32'h0,   "unmapped6"};
    vecs[7]  = '{1'b0, 3'd7, 32'h0,        32'h0,   "unmapped7"};
    vecs[8]  = '{1'b1, 3'd5, 32'hFFFFF3FF, 32'h0,   ""};
    vecs[9]  = '{1'b0, 3'd5, 32'h0,        32'h3FF, "exp_mask"};
    vecs[10] = '{1'b1, 3'd5, 32'd480,      32'h0,   ""};
    vecs[11] = '{1'b1, 3'd0, 32'h5,        32'h0,   ""};
    vecs[12] = '{1'b0, 3'd0, 32'h0,        32'h2,   "id_ro"};
    vecs[13] = '{1'b1, 3'd1, 32'hFFFFFFE6, 32'h0,   ""};
    vecs[14] = '{1'b0, 3'd1, 32'h0,        32'h6,   "ctrl_mask"};
    vecs[15] = '{1'b1, 3'd4, 32'h5,        32'h0,   ""};
    vecs[16] = '{1'b0, 3'd4, 32'h0,        32'h0,   "last_ro"};
    vecs[17] = '{1'b1, 3'd1, 32'h18,       32'h0,   ""};
    vecs[18] = '{1'b0, 3'd1, 32'h0,        32'h18,  "ctrl_pat"};
    repeat (3) tick;
    chk("rst_capture_en", capture_en, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", led_busy, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_readdata", readdata, 0);
    reset = 0;
    repeat (7) tick;
    chk("hb_low", led_heartbeat2, 0);
    tick;
    chk("hb_high", led_heartbeat2, 1);
    for (int i = 0; i < 19; i++)
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
      else begin
        bus_rd(vecs[i].addr);
        chk(vecs[i].name, rdata, vecs[i].exp);
      end
    chk("pattern_sel", pattern_sel, 3);
    tick; tick;
    chk("rd_hold", readdata, 32'h18);
    bus_wr(3'd1, 32'h0);
    // continuous capture, three full frames
    bus_wr(3'd1, 32'h1);
    fs0 = fs_cnt;
    repeat (3) frame(480);
    chk("cont_fs_pulses", fs_cnt - fs0, 3);
    bus_rd(3'd3); chk("cont_fcnt", rdata, 3);
    bus_rd(3'd4); chk("cont_last", rdata, 480);
    bus_rd(3'd2); chk("cont_status", rdata, 32'h1);
    bus_wr(3'd1, 32'h0);
    // single-shot short frame with irq
    bus_wr(3'd1, 32'h7);
    frame(479);
    chk("single_irq", irq, 1);
    bus_rd(3'd2); chk("single_status", rdata, 32'h6);
    bus_rd(3'd1); chk("single_ctrl", rdata, 32'h6);
    bus_rd(3'd3); chk("single_fcnt", rdata, 4);
    chk("fcnt_wrap", rdata2, 0);
    bus_rd(3'd4); chk("single_last", rdata, 479);
    bus_wr(3'd2, 32'h6);
    bus_rd(3'd2); chk("w1c_status", rdata, 0);
    chk("w1c_irq", irq, 0);
    // abort mid-frame
    bus_wr(3'd1, 32'h1);
    cam_vsync = 0;
    repeat (4) tick;
    line_pulses(200);
    chk("abort_pre_ce", capture_en, 1);
    chk("abort_pre_busy", led_busy, 1);
    bus_wr(3'd1, 32'h0);
    tick;
    chk("abort_ce", capture_en, 0);
    cam_vsync = 1;
    repeat (8) tick;
    bus_rd(3'd3); chk("abort_fcnt", rdata, 4);
    bus_rd(3'd4); chk("abort_last", rdata, 479);
    // W1C of done on the same edge hardware sets it
    bus_wr(3'd5, 32'd8);
    bus_wr(3'd1, 32'h3);
    frame_body(8);
    wait_drop("w1c_race_drop");
    bus_wr(3'd2, 32'h2);
    bus_rd(3'd2); chk("w1c_race_status", rdata, 32'h2);
    bus_rd(3'd1); chk("w1c_race_ctrl", rdata, 32'h2);
    bus_wr(3'd2, 32'h2);
    bus_rd(3'd2); chk("w1c_after", rdata, 0);
    // CPU re-enable on the same edge DONE clears enable
    bus_wr(3'd1, 32'h3);
    frame_body(8);
    wait_drop("cpu_win_drop");
    bus_wr(3'd1, 32'h3);
    bus_rd(3'd1); chk("cpu_win_ctrl", rdata, 32'h3);
    chk("cpu_win_busy", led_busy, 1);
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd2, 32'h6);
    bus_rd(3'd3); chk("cpu_win_fcnt", rdata, 6);
    // FRAME_CNT clear on the same edge as the frame-end increment
    bus_wr(3'd1, 32'h1);
    frame_body(8);
    tick; tick;
    bus_wr(3'd3, 32'h0);
    chk("clr_inc_ce_edge", capture_en, 0);
    bus_rd(3'd3); chk("clr_inc_fcnt", rdata, 1);
    chk("clr_inc_fcnt2", rdata2, 1);
    bus_rd(3'd4); chk("clr_inc_last", rdata, 8);
    bus_wr(3'd1, 32'h0);
    // reset mid-capture
    bus_wr(3'd1, 32'h19);
    cam_vsync = 0;
    repeat (4) tick;
    line_pulses(3);
    chk("mid_ce", capture_en, 1);
    bus_rd(3'd0);
    reset = 1;
    tick;
    chk("mrst_ce", capture_en, 0);
    chk("mrst_busy", led_busy, 0);
    chk("mrst_pat", pattern_sel, 0);
    chk("mrst_irq", irq, 0);
    chk("mrst_fs", frame_start, 0);
    chk("mrst_rd", readdata, 0);
    chk("mrst_hb", led_heartbeat2, 0);
    reset = 0;
    tick;
    bus_rd(3'd1); chk("mrst_ctrl", rdata, 0);
    bus_rd(3'd5); chk("mrst_exp", rdata, 480);
    bus_rd(3'd3); chk("mrst_fcnt", rdata, 0);
    bus_wr(3'd1, 32'h1);
    fs0 = fs_cnt;
    line_pulses(3);
    chk("mrst_no_resume", capture_en, 0);
    cam_vsync = 1;
    repeat (8) tick;
    chk("mrst_no_fs", fs_cnt - fs0, 0);
    bus_rd(3'd3); chk("mrst_fcnt_after", rdata, 0);
    // asynchronous camera timing with random phase
    fs0 = fs_cnt;
    repeat (4) begin
      #($urandom_range(1, 9));
      cam_vsync = 0;
      #($urandom_range(40, 60));
      repeat (4) begin
        cam_href = 1;
        #($urandom_range(20, 30));
        cam_href = 0;
        #($urandom_range(20, 30));
      end
      #30;
      cam_vsync = 1;
      #($urandom_range(80, 120));
    end
    tick;
    chk("async_fs", fs_cnt - fs0, 4);
    bus_rd(3'd3); chk("async_fcnt", rdata, 4);
    bus_rd(3'd4); chk("async_last", rdata, 4);
    chk("async_irq", irq, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
